mb_upconverter: RTL

- Bridges a 16-bit-data requester onto a 32-bit-data memory bus. Used for data-side and debug accesses that sit on the wide instruction memory port.
- Each downstream fetch returns one 32-bit word. The block keeps it in a single-entry line buffer with a tag.
- A following request to the other halfword of that word is served from the buffer without a new downstream transaction.
- Both sides use the team memory-bus request protocol: address/active held until a one-cycle data_valid pulse.

---
 rtl/mb_upconverter_if.sv | 31 +++
 rtl/mb_upconverter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mb_upconverter_if.sv
`default_nettype none
// ============================================================================
// Module      : mb_upconverter_if
// Description : Memory-bus request channel. Address and active are held
//               until a one-cycle data_valid pulse.
// Revision    : 1.0
// ============================================================================
interface mb_upconverter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] req_addr;
    logic          req_active;
    logic [DW-1:0] req_data;
    logic          req_data_valid;

    modport master (
        output req_addr,
        output req_active,
        input  req_data,
        input  req_data_valid
    );

    modport slave (
        input  req_addr,
        input  req_active,
        output req_data,
        output req_data_valid
    );
endinterface
`default_nettype wire

// File: rtl/mb_upconverter.sv
`default_nettype none
// ============================================================================
// Module      : mb_upconverter
// Description : 16-bit requester onto 32-bit memory bus with a one-word,
//               tagged line buffer serving the sibling halfword.
// Revision    : 1.0
// ============================================================================
module mb_upconverter #(
    parameter int RW = 16,
    parameter int DW = 2 * RW
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_inval,
    mb_upconverter_if.slave       u,
    mb_upconverter_if.master      d
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  u_data_q, u_data_d;
    logic           u_valid_q, u_valid_d;
    logic [RW-1:0]  d_addr_q, d_addr_d;
    logic           d_active_q, d_active_d;
    logic [DW-1:0]  buf_data_q, buf_data_d;
    logic [RW-2:0]  buf_tag_q, buf_tag_d;
    logic           buf_valid_q, buf_valid_d;
    logic           inval_seen_q, inval_seen_d;

    logic           w_hit;
    logic [RW-1:0]  w_buf_half;
    logic [RW-1:0]  w_fill_half;

    assign w_hit       = buf_valid_q & ~i_inval & (buf_tag_q == u.req_addr[RW-1:1]);
    assign w_buf_half  = u.req_addr[0] ? buf_data_q[DW-1:RW] : buf_data_q[RW-1:0];
    assign w_fill_half = u.req_addr[0] ? d.req_data[DW-1:RW] : d.req_data[RW-1:0];

    assign u.req_data       = u_data_q;
    assign u.req_data_valid = u_valid_q;
    assign d.req_addr       = d_addr_q;
    assign d.req_active     = d_active_q;

    always_comb begin
        state_d      = state_q;
        u_data_d     = u_data_q;
        u_valid_d    = 1'b0;
        d_addr_d     = d_addr_q;
        d_active_d   = d_active_q;
        buf_data_d   = buf_data_q;
        buf_tag_d    = buf_tag_q;
        buf_valid_d  = buf_valid_q & ~i_inval;
        inval_seen_d = inval_seen_q | i_inval;

        case (state_q)
            S_IDLE: begin
                // An invalidate before the fetch starts does not taint the data fetched afterwards.
                inval_seen_d = 1'b0;
                if (u.req_active) begin
                    if (w_hit) begin
                        u_data_d  = w_buf_half;
                        u_valid_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        d_addr_d   = {1'b0, u.req_addr[RW-1:1]};
                        d_active_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (d.req_data_valid) begin
                    d_active_d   = 1'b0;
                    buf_data_d   = d.req_data;
                    buf_tag_d    = d_addr_q[RW-2:0];
                    buf_valid_d  = ~(inval_seen_q | i_inval);
                    inval_seen_d = 1'b0;
                    if (u.req_active) begin
                        u_data_d  = w_fill_half;
                        u_valid_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESP: begin
                // Requester address may still be stale here, so the request is not sampled.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            u_data_q     <= '0;
            u_valid_q    <= 1'b0;
            d_addr_q     <= '0;
            d_active_q   <= 1'b0;
            buf_data_q   <= '0;
            buf_tag_q    <= '0;
            buf_valid_q  <= 1'b0;
            inval_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            u_data_q     <= u_data_d;
            u_valid_q    <= u_valid_d;
            d_addr_q     <= d_addr_d;
            d_active_q   <= d_active_d;
            buf_data_q   <= buf_data_d;
            buf_tag_q    <= buf_tag_d;
            buf_valid_q  <= buf_valid_d;
            inval_seen_q <= inval_seen_d;
        end
    end

endmodule
`default_nettype wire
